eth_tx_framer: RTL and testbench
================================

Name: eth_tx_framer

Overview:
Synthesizable MII transmit framer for the Ethernet controller, sitting between the ZBT frame-buffer read port and the PHY transmit pins. On a send request it reads a word range from the buffer and emits back-to-back Ethernet frames. Each frame carries a 6-byte range header and up to PAYLOAD_WORDS 32-bit words, followed by CRC32. On a pause request it emits a single header-only request frame.

Parameters:
PAYLOAD_WORDS, 256, max payload words per frame (power of 2, 16..256)
IFG_NIBBLES, 24, idle nibbles before every frame (96 bit times)
SRC_MAC, 48'h00_0A_35_00_00_01, source MAC inserted in every frame
MIN_WORDS, 10, minimum payload words; short payloads are zero-padded to this (6-byte header + 40 bytes = 46-byte Ethernet minimum)

Ports:
clock_25  in  1  system/MII transmit clock, one nibble per cycle
resetn  in  1  asynchronous, active-low reset
Start_send_I  in  1  send request, rising edge sampled in IDLE
Start_pause_I  in  1  request-frame trigger, rising edge sampled in IDLE
Dest_MAC_I  in  48  destination MAC, latched at start
Type_I  in  16  EtherType, latched at start
Range_begin_I  in  24  first word address (inclusive), latched at start
Range_end_I  in  24  last word address (inclusive), latched at start
TX_data_I  in  32  buffer read data for Address_O
TX_read_ack_O  out  1  one-cycle pulse when TX_data_I is consumed
Address_O  out  24  buffer word read address
TX_ERROR_P  in  1  PHY transmit error
TX_DATA_P  out  4  MII nibble
TX_ENABLE_P  out  1  MII transmit enable
Active_tx_O  out  1  high from first IFG cycle until the final frame's last CRC nibble
Error_O  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0. Reset mid-frame drops TX_ENABLE_P asynchronously. The FSM returns to IDLE, the job is abandoned and Error_O is cleared.
- Starts:
  - Starts are accepted only in IDLE, on a 0->1 edge. The edge detector's previous-value register is updated every cycle.
  - If both inputs rise in the same cycle, send wins and the pause edge is discarded.
  - Edges seen outside IDLE are ignored.
- Range check on a send start:
  - If Range_end_I < Range_begin_I, set Error_O, send nothing and stay in IDLE.
  - Otherwise clear Error_O and set cur = Range_begin_I.
- FSM: IDLE -> IFG (IFG_NIBBLES cycles, TX_ENABLE_P=0) -> PRE (15 nibbles 0x5) -> SFD (0xD) -> DST (12) -> SRC (12) -> TYPE (4) -> RANGE (12) -> PAYLOAD -> PAD -> CRC (8) -> IFG if words remain, else IDLE.
- TX_ENABLE_P is 1 from PRE through CRC inclusive and 0 otherwise. There are no gaps between frames other than IFG.
- Byte order: fields are sent MSB byte first, each byte low nibble first.
  - Word bytes go out in the order [31:24], [23:16], [15:8], [7:0].
  - Type_I goes out as [15:8] then [7:0].
- Range header: 24-bit first-word address then 24-bit last-word address of this frame, each MSB byte first.
- Frame sizing: n = min(PAYLOAD_WORDS, Range_end - cur + 1). Widths are 25-bit internally so that a range of 24'h000000..24'hFFFFFF does not overflow.
- Payload read handshake:
  - Address_O = cur whenever the next word is pending.
  - On the first nibble cycle of each word, latch TX_data_I, pulse TX_read_ack_O and increment Address_O.
  - This guarantees at least 8 cycles of read latency for the next word.
  - Address_O is loaded with Range_begin_I at start; the first word is sampled at the start of PAYLOAD, more than 60 cycles later.
- Padding:
  - If n < MIN_WORDS, PAD emits (MIN_WORDS - n)*8 zero nibbles.
  - No reads or acks occur during PAD.
- Pause/request frame:
  - Header fields as above; range header = latched Range_begin_I / Range_end_I.
  - n = 0, PAD emits MIN_WORDS words of zeros, then CRC.
  - Address_O is unchanged and there are no acks.
- CRC32 (IEEE 802.3):
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, nibble-serial.
  - Covers DST through PAD.
  - The complemented result is sent least-significant nibble first.
- TX_ERROR_P high in any TX_ENABLE_P cycle sets sticky Error_O. The frame still completes.
- Active_tx_O falls in the cycle after the last CRC nibble.

Optional Feature:
ETH_TX_STATS_EN:
- Defined: adds output Frame_count_O [15:0], reset 0, incremented when a CRC state completes, wrapping at 16'hFFFF -> 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. Send with Range 0x000100..0x0002FF -> 2 frames of 256 words.
   - Each frame is 16+12+12+4+12+2048+8 = 2112 enabled nibbles.
   - Headers are 000100/0001FF and 000200/0002FF.
   - 512 acks; final Address_O = 0x000300.
   - CRC matches the bench model.
2. Send with Range 0x000010..0x000012 -> one frame of 3 words plus 7 zero words of pad; exactly 3 acks.
3. Pause pulse with Type_I=16'h88B5 -> one frame: header 0x88B5, 80 zero pad nibbles, 0 acks, Address_O unchanged.
4. Send with Range_begin_I=0x000020, Range_end_I=0x00001F -> Error_O=1, TX_ENABLE_P stays 0; a following valid send clears Error_O.
5. Send and pause rising in the same cycle -> only the data frames are sent. Start_send_I re-pulsed mid-frame -> ignored.
6. resetn low during PAYLOAD of test 1 -> TX_ENABLE_P drops immediately and all outputs are 0. After release the block is idle until the next edge, and stats (if enabled) read 0.

Source files
------------

// File: rtl/eth_tx_framer_if.sv
// Buffer read port and MII transmit pins of the Ethernet transmit framer.
// master: framer side (drives address/ack and the MII nibble bus).
// slave: buffer/PHY side (returns read data and the PHY error strobe).
interface eth_tx_framer_if;
  logic [31:0] TX_data_I;
  logic        TX_read_ack_O;
  logic [23:0] Address_O;
  logic        TX_ERROR_P;
  logic [3:0]  TX_DATA_P;
  logic        TX_ENABLE_P;

  modport master (
    input  TX_data_I, TX_ERROR_P,
    output TX_read_ack_O, Address_O, TX_DATA_P, TX_ENABLE_P
  );

  modport slave (
    output TX_data_I, TX_ERROR_P,
    input  TX_read_ack_O, Address_O, TX_DATA_P, TX_ENABLE_P
  );
endinterface

// File: rtl/eth_tx_framer.sv
// MII transmit framer: streams a buffer word range as back-to-back Ethernet frames (or one pause frame).
// Latency: first preamble nibble IFG_NIBBLES cycles after the start edge; one nibble per clock_25 cycle.
// Backpressure: none; the buffer must return TX_data_I for Address_O within 8 cycles of each ack.
// Optional: define ETH_TX_STATS_EN to add the Frame_count_O frame counter.
module eth_tx_framer #(
  parameter int          PAYLOAD_WORDS = 256,
  parameter int          IFG_NIBBLES   = 24,
  parameter logic [47:0] SRC_MAC       = 48'h00_0A_35_00_00_01,
  parameter int          MIN_WORDS     = 10
) (
  input  logic        clock_25,
  input  logic        resetn,
  input  logic        Start_send_I,
  input  logic        Start_pause_I,
  input  logic [47:0] Dest_MAC_I,
  input  logic [15:0] Type_I,
  input  logic [23:0] Range_begin_I,
  input  logic [23:0] Range_end_I,
  eth_tx_framer_if.master bus,
  output logic        Active_tx_O,
`ifdef ETH_TX_STATS_EN
  output logic [15:0] Frame_count_O,
`endif
  output logic        Error_O
);

  typedef enum logic [3:0] {
    S_IDLE, S_IFG, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_RANGE, S_PAYLOAD, S_PAD, S_CRC
  } state_t;

  localparam logic [24:0] PW25 = 25'(PAYLOAD_WORDS);
  localparam logic [8:0]  PW9  = 9'(PAYLOAD_WORDS);
  localparam logic [8:0]  MINW = 9'(MIN_WORDS);

  state_t      state, state_nxt;
  logic [11:0] cnt, state_len;
  logic        last_nib, tx_en, ack;
  logic [3:0]  nib;
  logic        send_prev, pause_prev, send_edge, pause_edge, range_bad, more;
  logic [47:0] dst_mac;
  logic [15:0] eth_type;
  logic [23:0] rng_begin, rng_end, frm_first, frm_last;
  logic [24:0] cur, rem_words;
  logic        is_pause, error_r;
  logic [8:0]  n_words, n_calc, pad_words;
  logic [31:0] word_reg, pay_word, crc, crc_sh;

  // Pick nibble idx (0..11) of a 6-byte field: MSB byte first, low nibble of each byte first.
  function automatic logic [3:0] nib48(input logic [47:0] v, input logic [3:0] idx);
    logic [47:0] s;
    s = v << {idx[3:1], 3'b000};
    return idx[0] ? s[47:44] : s[43:40];
  endfunction

  // One nibble of reflected CRC-32 (poly 0xEDB88320), bit 0 of the nibble first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c ^ {28'h0, d};
    for (int i = 0; i < 4; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign send_edge  = Start_send_I & ~send_prev;
  assign pause_edge = Start_pause_I & ~pause_prev;
  assign range_bad  = Range_end_I < Range_begin_I;
  assign more       = !is_pause && ({1'b0, rng_end} >= cur);
  // 25-bit so a full 000000..FFFFFF range does not wrap.
  assign rem_words  = {1'b0, rng_end} - cur + 25'd1;
  assign n_calc     = (rem_words > PW25) ? PW9 : rem_words[8:0];
  assign pad_words  = MINW - n_words;

  // State register; reset abandons any job mid-frame.
  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Per-state nibble count, next state and MII/ack outputs.
  always_comb begin
    state_nxt = state;
    state_len = 12'd0;
    nib       = 4'h0;
    tx_en     = 1'b0;
    ack       = 1'b0;
    crc_sh    = (~crc) >> {cnt[2:0], 2'b00};
    // The first nibble of a word comes straight from the buffer; the rest from the latched copy.
    pay_word  = (cnt[2:0] == 3'd0) ? bus.TX_data_I : word_reg;
    case (state)
      S_IFG:     state_len = 12'(IFG_NIBBLES - 1);
      S_PRE:     begin state_len = 12'd14; tx_en = 1'b1; nib = 4'h5; end
      S_SFD:     begin state_len = 12'd0;  tx_en = 1'b1; nib = 4'hD; end
      S_DST:     begin state_len = 12'd11; tx_en = 1'b1; nib = nib48(dst_mac, cnt[3:0]); end
      S_SRC:     begin state_len = 12'd11; tx_en = 1'b1; nib = nib48(SRC_MAC, cnt[3:0]); end
      S_TYPE:    begin state_len = 12'd3;  tx_en = 1'b1; nib = nib48({32'h0, eth_type}, cnt[3:0] + 4'd8); end
      S_RANGE:   begin state_len = 12'd11; tx_en = 1'b1; nib = nib48({frm_first, frm_last}, cnt[3:0]); end
      S_PAYLOAD: begin
        state_len = {n_words, 3'b000} - 12'd1;
        tx_en     = 1'b1;
        nib       = nib48({16'h0, pay_word}, {1'b0, cnt[2:0]} + 4'd4);
        ack       = (cnt[2:0] == 3'd0);
      end
      S_PAD:     begin state_len = {pad_words, 3'b000} - 12'd1; tx_en = 1'b1; end
      S_CRC:     begin state_len = 12'd7; tx_en = 1'b1; nib = crc_sh[3:0]; end
      default:   state_len = 12'd0;
    endcase
    last_nib = (cnt == state_len);
    case (state)
      S_IDLE:    if ((send_edge && !range_bad) || (!send_edge && pause_edge)) state_nxt = S_IFG;
      S_IFG:     if (last_nib) state_nxt = S_PRE;
      S_PRE:     if (last_nib) state_nxt = S_SFD;
      S_SFD:     state_nxt = S_DST;
      S_DST:     if (last_nib) state_nxt = S_SRC;
      S_SRC:     if (last_nib) state_nxt = S_TYPE;
      S_TYPE:    if (last_nib) state_nxt = S_RANGE;
      S_RANGE:   if (last_nib) state_nxt = (n_words == 9'd0) ? S_PAD : S_PAYLOAD;
      S_PAYLOAD: if (last_nib) state_nxt = (n_words < MINW) ? S_PAD : S_CRC;
      S_PAD:     if (last_nib) state_nxt = S_CRC;
      S_CRC:     if (last_nib) state_nxt = more ? S_IFG : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Job latching, frame sizing, read pointer, CRC accumulation and sticky error.
  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0; send_prev <= 1'b0; pause_prev <= 1'b0;
      dst_mac <= '0; eth_type <= '0; rng_begin <= '0; rng_end <= '0;
      frm_first <= '0; frm_last <= '0; cur <= '0; n_words <= '0;
      is_pause <= 1'b0; error_r <= 1'b0; word_reg <= '0; crc <= '1;
    end else begin
      send_prev  <= Start_send_I;
      pause_prev <= Start_pause_I;
      cnt <= (state_nxt != state || state == S_IDLE) ? 12'd0 : cnt + 12'd1;
      if (state == S_IDLE) begin
        if (send_edge) begin
          if (range_bad) error_r <= 1'b1;
          else begin
            error_r <= 1'b0; is_pause <= 1'b0; cur <= {1'b0, Range_begin_I};
            dst_mac <= Dest_MAC_I; eth_type <= Type_I;
            rng_begin <= Range_begin_I; rng_end <= Range_end_I;
          end
        end else if (pause_edge) begin
          is_pause <= 1'b1; dst_mac <= Dest_MAC_I; eth_type <= Type_I;
          rng_begin <= Range_begin_I; rng_end <= Range_end_I;
        end
      end
      if (state == S_IFG && last_nib) begin
        if (is_pause) begin
          n_words <= 9'd0; frm_first <= rng_begin; frm_last <= rng_end;
        end else begin
          n_words <= n_calc; frm_first <= cur[23:0];
          frm_last <= cur[23:0] + 24'(n_calc) - 24'd1;
        end
      end
      if (ack) begin
        word_reg <= bus.TX_data_I;
        cur      <= cur + 25'd1;
      end
      if (state == S_SFD) crc <= 32'hFFFFFFFF;
      else if (state inside {S_DST, S_SRC, S_TYPE, S_RANGE, S_PAYLOAD, S_PAD}) crc <= crc_step(crc, nib);
      if (tx_en && bus.TX_ERROR_P) error_r <= 1'b1;
    end
  end

`ifdef ETH_TX_STATS_EN
  logic [15:0] frame_cnt;
  // Count frames whose CRC has been fully emitted; wraps naturally.
  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn)                     frame_cnt <= '0;
    else if (state == S_CRC && last_nib) frame_cnt <= frame_cnt + 16'd1;
  end
  assign Frame_count_O = frame_cnt;
`endif

  assign bus.TX_DATA_P     = nib;
  assign bus.TX_ENABLE_P   = tx_en;
  assign bus.TX_read_ack_O = ack;
  assign bus.Address_O     = cur[23:0];
  assign Active_tx_O       = (state != S_IDLE);
  assign Error_O           = error_r;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: captures MII nibbles per frame and compares them to a frame model.
module tb_eth_tx_framer;
  logic        clock_25 = 1'b0;
  logic        resetn;
  logic        Start_send_I, Start_pause_I;
  logic [47:0] Dest_MAC_I;
  logic [15:0] Type_I;
  logic [23:0] Range_begin_I, Range_end_I;
  logic        Active_tx_O, Error_O;
`ifdef ETH_TX_STATS_EN
  logic [15:0] Frame_count_O;
`endif

  eth_tx_framer_if bus();

  eth_tx_framer dut (
    .clock_25(clock_25), .resetn(resetn),
    .Start_send_I(Start_send_I), .Start_pause_I(Start_pause_I),
    .Dest_MAC_I(Dest_MAC_I), .Type_I(Type_I),
    .Range_begin_I(Range_begin_I), .Range_end_I(Range_end_I),
    .bus(bus), .Active_tx_O(Active_tx_O),
`ifdef ETH_TX_STATS_EN
    .Frame_count_O(Frame_count_O),
`endif
    .Error_O(Error_O)
  );

  always #20 clock_25 = ~clock_25;

  // Buffer contents as a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h17, a[23:16], ~a[7:0]};
  endfunction
  assign bus.TX_data_I = mem_word(bus.Address_O);

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c ^ {28'h0, d};
    for (int i = 0; i < 4; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  int vectors = 0, miscompares = 0;
  logic [3:0] cap[$];
  int flen[$], fstart[$];
  int cur_len = 0, acks = 0, active_cyc = 0;
  logic [3:0] exp_q[$];

  always @(negedge clock_25) begin
    if (bus.TX_ENABLE_P) begin
      cap.push_back(bus.TX_DATA_P);
      cur_len++;
    end else if (cur_len != 0) begin
      flen.push_back(cur_len);
      fstart.push_back(cap.size() - cur_len);
      cur_len = 0;
    end
    if (bus.TX_read_ack_O) acks++;
    if (Active_tx_O) active_cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic snd, input logic pse);
    @(negedge clock_25);
    Start_send_I = snd; Start_pause_I = pse;
    @(negedge clock_25);
    Start_send_I = 1'b0; Start_pause_I = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (Active_tx_O && k < budget) begin @(negedge clock_25); k++; end
    chk({tag, " finished within budget"}, Active_tx_O, 1'b0);
    repeat (2) @(negedge clock_25);
  endtask

  task automatic wait_enable(input int budget, input string tag);
    int k = 0;
    while (!bus.TX_ENABLE_P && k < budget) begin @(negedge clock_25); k++; end
    chk({tag, " frame started"}, bus.TX_ENABLE_P, 1'b1);
  endtask

  task automatic push_bytes(input logic [47:0] v, input int nbytes);
    for (int b = nbytes - 1; b >= 0; b--) begin
      logic [7:0] by;
      by = v[8*b +: 8];
      exp_q.push_back(by[3:0]);
      exp_q.push_back(by[7:4]);
    end
  endtask

  // Build the expected frame and compare it, plus header fields and CRC residue, to captured frame fidx.
  task automatic check_frame(input string tag, input int fidx, input logic [47:0] dst, input logic [15:0] typ,
                             input logic [47:0] hdr, input logic [23:0] waddr, input int nwords, input int padw);
    logic [31:0] c;
    logic [47:0] got_hdr;
    int off, nbad;
    if (fidx >= flen.size()) return;
    exp_q.delete();
    repeat (15) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    push_bytes(dst, 6);
    push_bytes(48'h00_0A_35_00_00_01, 6);
    push_bytes({32'h0, typ}, 2);
    push_bytes(hdr, 6);
    for (int i = 0; i < nwords; i++) push_bytes({16'h0, mem_word(waddr + 24'(i))}, 4);
    repeat (padw * 8) exp_q.push_back(4'h0);
    c = 32'hFFFFFFFF;
    for (int i = 16; i < exp_q.size(); i++) c = crc_nib(c, exp_q[i]);
    c = ~c;
    for (int k = 0; k < 8; k++) exp_q.push_back(c[4*k +: 4]);
    off = fstart[fidx];
    chk({tag, " length"}, flen[fidx], exp_q.size());
    nbad = 0;
    for (int i = 0; i < flen[fidx] && i < exp_q.size(); i++) if (cap[off + i] !== exp_q[i]) nbad++;
    chk({tag, " bad nibbles"}, nbad, 0);
    if (flen[fidx] >= 56) begin
      got_hdr = '0;
      for (int b = 0; b < 6; b++) got_hdr = {got_hdr[39:0], cap[off + 45 + 2*b], cap[off + 44 + 2*b]};
      chk({tag, " range header"}, got_hdr, hdr);
      chk({tag, " type"}, {cap[off+41], cap[off+40], cap[off+43], cap[off+42]}, typ);
      c = 32'hFFFFFFFF;
      for (int i = 16; i < flen[fidx]; i++) c = crc_nib(c, cap[off + i]);
      chk({tag, " crc residue"}, c, 32'hDEBB20E3);
    end
  endtask

  initial begin
    int bf, a0, c0, k0;
    resetn = 1'b0; Start_send_I = 1'b0; Start_pause_I = 1'b0; bus.TX_ERROR_P = 1'b0;
    Dest_MAC_I = 48'h02_11_22_33_44_55; Type_I = 16'h0800;
    Range_begin_I = '0; Range_end_I = '0;
    #5;
    chk("reset TX_ENABLE_P", bus.TX_ENABLE_P, 0);
    chk("reset TX_DATA_P", bus.TX_DATA_P, 0);
    chk("reset ack", bus.TX_read_ack_O, 0);
    chk("reset Address_O", bus.Address_O, 0);
    chk("reset Active_tx_O", Active_tx_O, 0);
    chk("reset Error_O", Error_O, 0);
    repeat (2) @(negedge clock_25);
    resetn = 1'b1;
    repeat (3) @(negedge clock_25);

    // 1: two full frames of 256 words
    Range_begin_I = 24'h000100; Range_end_I = 24'h0002FF;
    bf = flen.size(); a0 = acks; c0 = active_cyc;
    pulse_start(1'b1, 1'b0);
    wait_idle(6000, "t1");
    chk("t1 frame count", flen.size() - bf, 2);
    check_frame("t1 f0", bf, 48'h02_11_22_33_44_55, 16'h0800, 48'h000100_0001FF, 24'h000100, 256, 0);
    check_frame("t1 f1", bf + 1, 48'h02_11_22_33_44_55, 16'h0800, 48'h000200_0002FF, 24'h000200, 256, 0);
    chk("t1 acks", acks - a0, 512);
    chk("t1 Address_O", bus.Address_O, 24'h000300);
    chk("t1 active cycles", active_cyc - c0, 4272);
`ifdef ETH_TX_STATS_EN
    chk("t1 Frame_count_O", Frame_count_O, 2);
`endif

    // 2: short frame with pad, PHY error mid-frame
    Range_begin_I = 24'h000010; Range_end_I = 24'h000012;
    bf = flen.size(); a0 = acks; c0 = active_cyc;
    pulse_start(1'b1, 1'b0);
    wait_enable(100, "t2");
    bus.TX_ERROR_P = 1'b1;
    @(negedge clock_25);
    bus.TX_ERROR_P = 1'b0;
    chk("t2 Error_O after TX_ERROR_P", Error_O, 1);
    wait_idle(500, "t2");
    chk("t2 frame count", flen.size() - bf, 1);
    check_frame("t2 f0", bf, 48'h02_11_22_33_44_55, 16'h0800, 48'h000010_000012, 24'h000010, 3, 7);
    chk("t2 acks", acks - a0, 3);
    chk("t2 active cycles", active_cyc - c0, 168);
    chk("t2 Error_O sticky", Error_O, 1);

    // 3: pause frame
    Dest_MAC_I = 48'h01_80_C2_00_00_01; Type_I = 16'h88B5;
    Range_begin_I = 24'h000500; Range_end_I = 24'h0005FF;
    bf = flen.size(); a0 = acks; c0 = active_cyc;
    pulse_start(1'b0, 1'b1);
    wait_idle(500, "t3");
    chk("t3 frame count", flen.size() - bf, 1);
    check_frame("t3 f0", bf, 48'h01_80_C2_00_00_01, 16'h88B5, 48'h000500_0005FF, 24'h0, 0, 10);
    chk("t3 acks", acks - a0, 0);
    chk("t3 Address_O unchanged", bus.Address_O, 24'h000013);
    chk("t3 active cycles", active_cyc - c0, 168);

    // 4: reversed range errors out; a valid send clears the error
    Dest_MAC_I = 48'h02_11_22_33_44_55; Type_I = 16'h0800;
    Range_begin_I = 24'h000020; Range_end_I = 24'h00001F;
    k0 = cap.size(); c0 = active_cyc;
    pulse_start(1'b1, 1'b0);
    repeat (30) @(negedge clock_25);
    chk("t4 Error_O on bad range", Error_O, 1);
    chk("t4 no enable nibbles", cap.size() - k0, 0);
    chk("t4 no active cycles", active_cyc - c0, 0);
    Range_begin_I = 24'h000030; Range_end_I = 24'h000030;
    bf = flen.size(); a0 = acks;
    pulse_start(1'b1, 1'b0);
    chk("t4 Error_O cleared by valid send", Error_O, 0);
    wait_idle(500, "t4");
    check_frame("t4 f0", bf, 48'h02_11_22_33_44_55, 16'h0800, 48'h000030_000030, 24'h000030, 1, 9);
    chk("t4 acks", acks - a0, 1);

    // 5: simultaneous send+pause, then a mid-frame send re-pulse
    Range_begin_I = 24'h000040; Range_end_I = 24'h000041;
    bf = flen.size(); a0 = acks;
    pulse_start(1'b1, 1'b1);
    wait_enable(100, "t5");
    repeat (20) @(negedge clock_25);
    Range_begin_I = 24'h000050; Range_end_I = 24'h000050;
    pulse_start(1'b1, 1'b0);
    wait_idle(500, "t5");
    repeat (40) @(negedge clock_25);
    chk("t5 frame count", flen.size() - bf, 1);
    check_frame("t5 f0", bf, 48'h02_11_22_33_44_55, 16'h0800, 48'h000040_000041, 24'h000040, 2, 8);
    chk("t5 acks", acks - a0, 2);
    chk("t5 Address_O", bus.Address_O, 24'h000042);
    chk("t5 idle afterwards", Active_tx_O, 0);

    // 6: reset during payload
    Range_begin_I = 24'h000100; Range_end_I = 24'h0002FF;
    a0 = acks;
    pulse_start(1'b1, 1'b0);
    for (int k = 0; k < 600 && (acks - a0) < 10; k++) @(negedge clock_25);
    chk("t6 reached payload", (acks - a0) >= 10, 1);
    bus.TX_ERROR_P = 1'b1;
    @(negedge clock_25);
    bus.TX_ERROR_P = 1'b0;
    chk("t6 Error_O before reset", Error_O, 1);
    chk("t6 enabled before reset", bus.TX_ENABLE_P, 1);
    #5 resetn = 1'b0;
    #1;
    chk("t6 reset TX_ENABLE_P", bus.TX_ENABLE_P, 0);
    chk("t6 reset TX_DATA_P", bus.TX_DATA_P, 0);
    chk("t6 reset ack", bus.TX_read_ack_O, 0);
    chk("t6 reset Address_O", bus.Address_O, 0);
    chk("t6 reset Active_tx_O", Active_tx_O, 0);
    chk("t6 reset Error_O", Error_O, 0);
    repeat (2) @(negedge clock_25);
    resetn = 1'b1;
    @(negedge clock_25);
    k0 = cap.size(); c0 = active_cyc;
    repeat (50) @(negedge clock_25);
    chk("t6 idle after release", active_cyc - c0, 0);
    chk("t6 no nibbles after release", cap.size() - k0, 0);
    chk("t6 Address_O after release", bus.Address_O, 0);
`ifdef ETH_TX_STATS_EN
    chk("t6 Frame_count_O after reset", Frame_count_O, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
